// File: rtl/simon_ti_pkg.sv
// rtl/simon_ti_pkg.sv - shared state encoding, data_rdy codes and Simon size defaults
package simon_ti_pkg;

  localparam int SIMON_P_SIZE = 128;
  localparam int SIMON_ROUNDS = 68;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] DR_IDLE = 2'd0;
  localparam logic [1:0] DR_LOAD = 2'd1;
  localparam logic [1:0] DR_HOLD = 2'd2;
  localparam logic [1:0] DR_RUN  = 2'd3;

endpackage

// File: rtl/simon_ti3_rnd_cnt.sv
// rtl/simon_ti3_rnd_cnt.sv - bit counter, round index and round parity for the RUN phase
module simon_ti3_rnd_cnt #(
  parameter int P_SIZE = 128,
  parameter int ROUNDS = 68,
  parameter int RN_W   = 7,
  parameter int BC_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  output logic            round_end_o,
  output logic            last_round_o,
  output logic [RN_W-1:0] round_num_o,
  output logic            round_par_o
);

  localparam logic [BC_W-1:0] BC_MAX  = BC_W'(P_SIZE/2 - 1);
  localparam logic [RN_W-1:0] RN_LAST = RN_W'(ROUNDS - 1);

  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RN_W-1:0] round_num_q, round_num_d;
  logic            par_q, par_d;

  assign round_end_o  = (bit_cnt_q == BC_MAX);
  assign last_round_o = (round_num_q == RN_LAST);
  assign round_num_o  = round_num_q;
  assign round_par_o  = par_q;

  // The final round saturates so the index stays valid through the DONE cycle.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    round_num_d = round_num_q;
    par_d       = par_q;
    if (clr_i) begin
      bit_cnt_d   = '0;
      round_num_d = '0;
      par_d       = 1'b0;
    end else if (en_i) begin
      if (round_end_o) begin
        bit_cnt_d = '0;
        if (!last_round_o) begin
          round_num_d = round_num_q + RN_W'(1);
          par_d       = ~par_q;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      round_num_q <= '0;
      par_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      round_num_q <= round_num_d;
      par_q       <= par_d;
    end
  end

endmodule

// File: rtl/simon_ti3_ctrl.sv
// rtl/simon_ti3_ctrl.sv - load/run sequencer for the 3-share Simon datapath; SIMON_CTRL_KEYCHK_EN enables key underflow abort
module simon_ti3_ctrl
  import simon_ti_pkg::*;
#(
  parameter int P_SIZE = SIMON_P_SIZE,
  parameter int ROUNDS = SIMON_ROUNDS,
  parameter int RN_W   = 7,
  parameter int BC_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pt_valid,
  output logic            pt_ready,
  input  logic            key_valid,
  output logic            key_req,
  output logic [1:0]      data_rdy,
  output logic            round_counter,
  output logic [RN_W-1:0] round_num,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int              LC_W    = $clog2(P_SIZE);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(P_SIZE - 1);

  ctrl_state_e     state_q, state_d;
  logic [LC_W-1:0] load_cnt_q, load_cnt_d;
  logic [1:0]      data_rdy_q, data_rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            key_abort;
  logic            round_end, last_round;

`ifdef SIMON_CTRL_KEYCHK_EN
  logic err_q;
  assign key_abort = (state_q == ST_RUN) && !key_valid;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (key_abort) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_key_valid;
  assign unused_key_valid = key_valid;
  assign key_abort        = 1'b0;
  assign err              = 1'b0;
`endif

  simon_ti3_rnd_cnt #(
    .P_SIZE(P_SIZE), .ROUNDS(ROUNDS), .RN_W(RN_W), .BC_W(BC_W)
  ) u_rnd_cnt (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == ST_RUN),
    .clr_i       (state_d == ST_IDLE),
    .round_end_o (round_end),
    .last_round_o(last_round),
    .round_num_o (round_num),
    .round_par_o (round_counter)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        load_cnt_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (pt_valid) begin
          if (load_cnt_q == LC_LAST) begin
            load_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            load_cnt_d = load_cnt_q + LC_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (key_abort) state_d = ST_IDLE;
        else if (round_end && last_round) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_LOAD: data_rdy_d = DR_LOAD;
      ST_RUN:  data_rdy_d = DR_RUN;
      default: data_rdy_d = DR_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      data_rdy_q <= DR_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      data_rdy_q <= data_rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // LOAD freezes the datapath shifters in the very cycle the share source stalls.
  assign data_rdy  = (state_q == ST_LOAD && !pt_valid) ? DR_HOLD : data_rdy_q;
  assign pt_ready  = (state_q == ST_LOAD) && pt_valid;
  assign key_req   = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_RUN) && (round_num >= RN_W'(ROUNDS - 2));
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_simon_ti3_ctrl.sv
// tb/tb_simon_ti3_ctrl.sv - directed vector bench for simon_ti3_ctrl
module tb_simon_ti3_ctrl;

  localparam int P       = 128;
  localparam int R       = 68;
  localparam int RUN_CYC = R * P / 2;

  logic       clk = 1'b0;
  logic       rst, start, pt_valid, key_valid;
  logic       pt_ready, key_req, round_counter, out_valid, busy, done, err;
  logic [1:0] data_rdy;
  logic [6:0] round_num;
  logic [15:0] act;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  simon_ti3_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .key_valid(key_valid), .key_req(key_req), .data_rdy(data_rdy),
    .round_counter(round_counter), .round_num(round_num), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  assign act = {data_rdy, pt_ready, key_req, round_counter, round_num, out_valid, busy, done, err};

  typedef struct {
    logic        r;
    logic        s;
    logic        pv;
    logic        kv;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [15:0] pk(input logic [1:0] dr, input logic ptr, input logic kr,
                                     input logic rc, input int rn, input logic ov,
                                     input logic bz, input logic dn, input logic er);
    return {dr, ptr, kr, rc, 7'(rn), ov, bz, dn, er};
  endfunction

  task automatic drive(input logic r, input logic s, input logic pv, input logic kv);
    @(posedge clk);
    #1;
    rst = r; start = s; pt_valid = pv; key_valid = kv;
    #3;
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got dr=%0d ptr=%b kr=%b rc=%b rn=%0d ov=%b busy=%b done=%b err=%b, expected %h (act %h)",
               nm, idx, act[15:14], act[13], act[12], act[11], act[10:4], act[3], act[2], act[1], act[0], e, act);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int e);
    n_vec++;
    if (got != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, e);
    end
  endtask

  // abort_kind: 0 none, 1 rst at RUN cycle abort_at, 2 key_valid low at RUN cycle abort_at
  task automatic encrypt(input bit toggle, input int abort_kind, input int abort_at);
    int acc, rn, ov_seen, done_seen;
    logic pv;
    acc = 0; ov_seen = 0; done_seen = 0;
    drive(0, 1, 1, 1);
    chk("start_idle", 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int j = 0; acc < P && j < 4 * P; j++) begin
      pv = toggle ? (j % 2 == 0) : 1'b1;
      drive(0, 0, pv, 1);
      chk("load", j, pk(pv ? 2'd1 : 2'd2, pv, 0, 0, 0, 0, 1, 0, 0));
      if (pv) acc++;
    end
    for (int r = 0; r < RUN_CYC; r++) begin
      rn = r / (P / 2);
      if (abort_kind != 0 && r == abort_at) begin
        drive(abort_kind == 1, 0, 1, abort_kind != 2);
        chk("abort_cycle", r, pk(3, 0, 1, rn[0], rn, rn >= R - 2, 1, 0, 0));
        drive(0, 0, 0, 1);
        chk("abort_idle", r, pk(0, 0, 0, 0, 0, 0, 0, 0, abort_kind == 2));
        drive(0, 0, 0, 1);
        chk("abort_stays_idle", r, pk(0, 0, 0, 0, 0, 0, 0, 0, abort_kind == 2));
        return;
      end
      drive(0, 0, 1, 1);
      chk("run", r, pk(3, 0, 1, rn[0], rn, rn >= R - 2, 1, 0, 0));
      if (out_valid) ov_seen++;
      if (done) done_seen++;
    end
    drive(0, 1, 0, 1);
    chk("done", 0, pk(0, 0, 0, 1, R - 1, 0, 1, 1, 0));
    if (done) done_seen++;
    drive(0, 0, 0, 1);
    chk("idle_after_done", 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_int("out_valid_cycles", ov_seen, P);
    chk_int("done_pulses", done_seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; pt_valid = 1'b0; key_valid = 1'b1;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, pk(1, 1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, pk(2, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, pk(1, 1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, pk(2, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, pk(1, 1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

    repeat (2) drive(1, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].pv, tbl[i].kv);
      chk("table", i, tbl[i].exp);
    end

    encrypt(1'b1, 1, 30 * (P / 2) + 5);
    encrypt(1'b0, 0, 0);

`ifdef SIMON_CTRL_KEYCHK_EN
    encrypt(1'b0, 2, 100);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      chk("err_sticky", k, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("err_cleared", 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
